// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that sequences an external 64-bit ALU.
// Ports: clk, rst_n, start/op_a/op_b in; busy/done/product out; alu_* drive/capture.
module alu_mul_sequencer #(
    parameter int          WIDTH     = 64,
    parameter logic [4:0]  FSEC_ADD  = 5'b00010,
    parameter logic [4:0]  FSEC_SHL  = 5'b01111,
    parameter logic [4:0]  FSEC_SHR  = 5'b10000,
    parameter logic [4:0]  FSEC_IDLE = 5'b01000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_fsec,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] alu_fout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam logic [6:0] CNT_LAST = 7'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [6:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_fsec  = FSEC_IDLE;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    if (op_b == '0) begin
                        state_d   = S_DONE;
                        product_d = '0;
                    end else if (op_b[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHL;
                    end
                end
            end
            S_ADD: begin
                alu_a    = acc_q;
                alu_b    = mcand_q;
                alu_fsec = FSEC_ADD;
                acc_d    = alu_fout;
                state_d  = S_SHL;
            end
            S_SHL: begin
                alu_a    = mcand_q;
                alu_fsec = FSEC_SHL;
                mcand_d  = alu_fout;
                state_d  = S_SHR;
            end
            S_SHR: begin
                alu_a    = mplier_q;
                alu_fsec = FSEC_SHR;
                mplier_d = alu_fout;
                cnt_d    = cnt_q + 7'd1;
                // stop once no multiplier bits remain
                if (alu_fout == '0 || cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    product_d = acc_q;
                end else if (alu_fout[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign product   = product_q;
    assign alu_carry = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer with a queue-based reference model.
// Also carries a behavioural 64-bit ALU driven by the DUT.
module tb_alu_mul_sequencer;

    localparam logic [4:0] F_ADD  = 5'b00010;
    localparam logic [4:0] F_SHL  = 5'b01111;
    localparam logic [4:0] F_SHR  = 5'b10000;
    localparam logic [4:0] F_IDLE = 5'b01000;

    logic        clk = 0;
    logic        rst_n;
    logic        start;
    logic [63:0] op_a, op_b;
    logic        busy, done;
    logic [63:0] product;
    logic [63:0] alu_a, alu_b, alu_fout;
    logic [4:0]  alu_fsec;
    logic        alu_carry;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    alu_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fsec(alu_fsec),
        .alu_carry(alu_carry), .alu_fout(alu_fout)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_fout = '0;
        case (alu_fsec)
            F_ADD:   alu_fout = alu_a + alu_b;
            F_SHL:   alu_fout = alu_a << 1;
            F_SHR:   alu_fout = alu_a >> 1;
            default: alu_fout = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 busy, 2 done. The queue holds the ALU opcode
    // expected in each remaining busy cycle.
    int          mst = 0;
    logic [4:0]  q[$];
    logic [63:0] mpend = '0;
    logic [63:0] mprod = '0;

    function automatic int msb_len(input logic [63:0] b);
        int n = 0;
        for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic int lat_of(input logic [63:0] b);
        int s = 0;
        for (int i = 0; i < msb_len(b); i++) s += 2 + int'(b[i]);
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst = 0;
            q.delete();
            mprod = '0;
        end else begin
            case (mst)
                0: if (start) begin
                    q.delete();
                    for (int i = 0; i < msb_len(op_b); i++) begin
                        if (op_b[i]) q.push_back(F_ADD);
                        q.push_back(F_SHL);
                        q.push_back(F_SHR);
                    end
                    mpend = op_a * op_b;
                    if (q.size() == 0) begin
                        mst = 2;
                        mprod = mpend;
                    end else mst = 1;
                end
                1: begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        mst = 2;
                        mprod = mpend;
                    end
                end
                default: mst = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] ef;
            ef = (mst == 1 && q.size() > 0) ? q[0] : F_IDLE;
            chk("busy", 64'(busy), 64'(mst != 0));
            chk("done", 64'(done), 64'(mst == 2));
            chk("product", product, mprod);
            chk("alu_fsec", 64'(alu_fsec), 64'(ef));
            chk("alu_carry", 64'(alu_carry), 64'd0);
            if (mst != 1) begin
                chk("alu_a_idle", alu_a, 64'd0);
                chk("alu_b_idle", alu_b, 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Issue one op from IDLE; lat counts edges after the accepting edge.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ep, input int el,
                          input bit noise);
        int n;
        start = 0;
        cyc();
        start = 1;
        op_a = a;
        op_b = b;
        cyc();
        start = 0;
        n = 0;
        while (!done && n < 400) begin
            cyc();
            n++;
            if (!done && noise) begin
                start = 1'($urandom);
                op_a = {$urandom, $urandom};
                op_b = {$urandom, $urandom};
            end
        end
        start = 0;
        if (n >= 400) $display("FAIL timeout: got %0d cycles, want done", n);
        chk("latency", 64'(n), 64'(el));
        chk("result", product, ep);
    endtask

    initial begin
        int n, last, pulses;
        logic [63:0] a, b;
        rst_n = 0;
        start = 0;
        op_a = '0;
        op_b = '0;
        repeat (3) cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_fsec", 64'(alu_fsec), 64'(F_IDLE));
        rst_n = 1;
        cyc();
        chk_en = 1;

        // hand-computed pins for the latency model
        chk("lat_model_3", 64'(lat_of(64'd3)), 64'd6);
        chk("lat_model_ones", 64'(lat_of('1)), 64'd192);
        chk("lat_model_6", 64'(lat_of(64'd6)), 64'd8);

        run_op(64'd5, 64'd3, 64'd15, 6, 0);
        run_op(64'h1234, 64'd0, 64'd0, 0, 0);
        run_op('1, '1, 64'd1, 192, 0);
        run_op(64'd0, 64'd5, 64'd0, 8, 0);

        // second start two cycles in is ignored
        start = 0;
        cyc();
        start = 1;
        op_a = 64'd7;
        op_b = 64'd6;
        cyc();
        start = 0;
        cyc();
        start = 1;
        op_a = 64'd9;
        op_b = 64'd9;
        cyc();
        start = 0;
        n = 2;
        while (!done && n < 400) begin
            cyc();
            n++;
        end
        chk("ignore_lat", 64'(n), 64'd8);
        chk("ignore_prod", product, 64'd42);

        // reset mid-operation
        cyc();
        start = 1;
        op_a = 64'd6;
        op_b = 64'd7;
        cyc();
        start = 0;
        repeat (3) cyc();
        rst_n = 0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        cyc();
        rst_n = 1;
        run_op(64'd2, 64'd2, 64'd4, 5, 0);

        // start held high: one result every 5 cycles
        cyc();
        start = 1;
        op_a = 64'd3;
        op_b = 64'd1;
        last = -1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (done) begin
                pulses++;
                if (last >= 0) chk("b2b_period", 64'(k - last), 64'd5);
                chk("b2b_prod", product, 64'd3);
                last = k;
            end
        end
        start = 0;
        chk("b2b_pulses", 64'(pulses), 64'd6);

        // random operands, with stray starts injected while busy
        for (int r = 0; r < 40; r++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (r % 10 == 0) b = '0;
            run_op(a, b, a * b, lat_of(b), 1'(r % 2));
        end
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
